// File: rtl/ebn_pkg.sv
// Shared helpers for the eb* elastic buffer family: sizing, pointer wrap and
// protocol assertion macro.
`ifndef EBN_PKG_MACROS
`define EBN_PKG_MACROS
`define EBN_ASSERT(name, prop) \
  name: assert property (@(posedge clk) disable iff (!reset_n) (prop));
`endif

package ebn_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ebn_ctrl.sv
// Control half of the N-entry elastic buffer: pointers, occupancy and the
// registered handshake flags.
module ebn_ctrl
  import ebn_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = clog2(DEPTH),
  parameter int unsigned CNTW  = clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            t_0_req,
  output logic            t_0_ack,
  output logic            i_0_req,
  input  logic            i_0_ack,
  input  logic            flush,
  output logic            wen,
  output logic [PTRW-1:0] wptr,
  output logic [PTRW-1:0] rptr,
  output logic [CNTW-1:0] count
);

  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            t_0_ack_q, t_0_ack_d;
  logic            i_0_req_q, i_0_req_d;
  logic            push, pop;

  assign push = t_0_req & t_0_ack_q;
  assign pop  = i_0_req_q & i_0_ack;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = PTRW'(ptr_inc(32'(wptr_q), DEPTH));
      if (pop)  rptr_d = PTRW'(ptr_inc(32'(rptr_q), DEPTH));
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
    // Flags come from the next count so they are registered, not combinational.
    t_0_ack_d = (count_d != CNTW'(DEPTH));
    i_0_req_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      t_0_ack_q <= 1'b1;
      i_0_req_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      t_0_ack_q <= t_0_ack_d;
      i_0_req_q <= i_0_req_d;
    end
  end

  assign wen     = push & ~flush;
  assign wptr    = wptr_q;
  assign rptr    = rptr_q;
  assign count   = count_q;
  assign t_0_ack = t_0_ack_q;
  assign i_0_req = i_0_req_q;

endmodule

// File: rtl/ebn_fifo.sv
// N-entry elastic buffer with registered req/ack flags, occupancy output and
// synchronous flush.
module ebn_fifo
  import ebn_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNTW  = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t_0_req,
  output logic             t_0_ack,
  input  logic [WIDTH-1:0] t_0_data,
  output logic             i_0_req,
  input  logic             i_0_ack,
  output logic [WIDTH-1:0] i_0_data,
  input  logic             flush,
  output logic [CNTW-1:0]  count
);

  localparam int unsigned PTRW = clog2(DEPTH);

  logic             wen;
  logic [PTRW-1:0]  wptr;
  logic [PTRW-1:0]  rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  ebn_ctrl #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW),
    .CNTW  (CNTW)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .t_0_req (t_0_req),
    .t_0_ack (t_0_ack),
    .i_0_req (i_0_req),
    .i_0_ack (i_0_ack),
    .flush   (flush),
    .wen     (wen),
    .wptr    (wptr),
    .rptr    (rptr),
    .count   (count)
  );

  // Storage is deliberately left unreset; the control flags guard its contents.
  always_ff @(posedge clk) begin
    if (wen) mem[wptr] <= t_0_data;
  end

  assign i_0_data = mem[rptr];

  `EBN_ASSERT(a_req_hold, $past(i_0_req && !i_0_ack && !flush) |-> i_0_req)
  `EBN_ASSERT(a_data_hold, $past(i_0_req && !i_0_ack && !flush) |-> $stable(i_0_data))
  `EBN_ASSERT(a_count_max, count <= CNTW'(DEPTH))

endmodule

// File: tb/tb_ebn_fifo.sv
// Directed bench for ebn_fifo: DEPTH=4 instance for fill/drain/full/flush/reset,
// DEPTH=3 instance for streaming with pointer wrap.
module tb_ebn_fifo;

  logic       clk;
  logic       reset_n;

  logic       a_t_req, a_t_ack, a_i_req, a_i_ack, a_flush;
  logic [7:0] a_t_data, a_i_data;
  logic [2:0] a_count;

  logic       b_t_req, b_t_ack, b_i_req, b_i_ack, b_flush;
  logic [7:0] b_t_data, b_i_data;
  logic [1:0] b_count;

  int unsigned n_checks;
  int unsigned n_fails;

  ebn_fifo #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk      (clk),
    .reset_n  (reset_n),
    .t_0_req  (a_t_req),
    .t_0_ack  (a_t_ack),
    .t_0_data (a_t_data),
    .i_0_req  (a_i_req),
    .i_0_ack  (a_i_ack),
    .i_0_data (a_i_data),
    .flush    (a_flush),
    .count    (a_count)
  );

  ebn_fifo #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk      (clk),
    .reset_n  (reset_n),
    .t_0_req  (b_t_req),
    .t_0_ack  (b_t_ack),
    .t_0_data (b_t_data),
    .i_0_req  (b_i_req),
    .i_0_ack  (b_i_ack),
    .i_0_data (b_i_data),
    .flush    (b_flush),
    .count    (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns later, well clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    a_t_req = 0; a_t_data = '0; a_i_ack = 0; a_flush = 0;
    b_t_req = 0; b_t_data = '0; b_i_ack = 0; b_flush = 0;
    step();
    step();
    check("rst_ack", 32'(a_t_ack), 1);
    check("rst_req", 32'(a_i_req), 0);
    check("rst_count", 32'(a_count), 0);
    reset_n = 1'b1;
    step();
    check("idle_ack", 32'(a_t_ack), 1);
    check("idle_req", 32'(a_i_req), 0);
    check("idle_count", 32'(a_count), 0);

    // Fill with consumer stalled.
    a_i_ack = 0;
    for (int i = 0; i < 4; i++) begin
      a_t_req  = 1;
      a_t_data = 8'((i + 1) * 8'h11);
      step();
      check("fill_count", 32'(a_count), 32'(i + 1));
      check("fill_req", 32'(a_i_req), 1);
    end
    check("full_ack", 32'(a_t_ack), 0);
    check("full_head", 32'(a_i_data), 32'h11);
    // Fifth request must be held off.
    a_t_data = 8'h99;
    step();
    check("held_count", 32'(a_count), 4);
    check("held_ack", 32'(a_t_ack), 0);

    // Pop at full while producer still requests: only the pop happens.
    a_i_ack = 1;
    step();
    a_t_req = 0;
    check("fullpop_count", 32'(a_count), 3);
    check("fullpop_ack", 32'(a_t_ack), 1);
    check("drain_d1", 32'(a_i_data), 32'h22);
    step();
    check("drain_d2", 32'(a_i_data), 32'h33);
    check("drain_c2", 32'(a_count), 2);
    step();
    check("drain_d3", 32'(a_i_data), 32'h44);
    check("drain_c3", 32'(a_count), 1);
    step();
    check("drain_req", 32'(a_i_req), 0);
    check("drain_count", 32'(a_count), 0);
    check("drain_ack", 32'(a_t_ack), 1);

    // Flush with two entries and a concurrent push.
    a_i_ack = 0;
    a_t_req = 1; a_t_data = 8'hA1; step();
    a_t_data = 8'hA2; step();
    check("pre_flush_count", 32'(a_count), 2);
    a_flush = 1; a_t_data = 8'h55;
    step();
    a_flush = 0;
    check("flush_count", 32'(a_count), 0);
    check("flush_req", 32'(a_i_req), 0);
    check("flush_ack", 32'(a_t_ack), 1);
    a_t_data = 8'h66;
    step();
    a_t_req = 0;
    check("postflush_req", 32'(a_i_req), 1);
    check("postflush_data", 32'(a_i_data), 32'h66);
    check("postflush_count", 32'(a_count), 1);
    a_i_ack = 1;
    step();
    check("postflush_empty", 32'(a_count), 0);

    // Asynchronous reset mid-stream with count=3.
    a_i_ack = 0;
    a_t_req = 1;
    for (int i = 0; i < 3; i++) begin
      a_t_data = 8'(i + 1);
      step();
    end
    a_t_req = 0;
    check("pre_rst_count", 32'(a_count), 3);
    reset_n = 0;
    #1;
    check("async_rst_count", 32'(a_count), 0);
    step();
    check("mid_rst_ack", 32'(a_t_ack), 1);
    check("mid_rst_req", 32'(a_i_req), 0);
    check("mid_rst_count", 32'(a_count), 0);
    reset_n = 1;
    step();

    // Streaming through the DEPTH=3 instance: 1-cycle latency, count steady at 1.
    b_t_req = 1;
    b_i_ack = 1;
    for (int i = 0; i < 10; i++) begin
      b_t_data = 8'(8'hC0 + i);
      step();
      check("stream_data", 32'(b_i_data), 32'(8'hC0 + i));
      check("stream_count", 32'(b_count), 1);
    end
    b_t_req = 0;
    step();
    check("stream_end_req", 32'(b_i_req), 0);
    check("stream_end_count", 32'(b_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
